// File: rtl/isqrt_seq.sv
// Iterative integer square root using a restoring digit-by-digit recurrence.
// Resolves STEPS root bits per clock, with optional saturating round-to-nearest.
module isqrt_seq #(
    parameter int unsigned W     = 16,
    parameter int unsigned STEPS = 1,
    parameter int unsigned ROUND = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [W-1:0]     i_x,
    output logic             o_ready,
    output logic             o_done,
    output logic [W/2-1:0]   o_y,
    output logic [W/2:0]     o_rem,
    output logic             o_sat
);

    localparam int unsigned H  = W / 2;
    localparam int unsigned N  = W / (2 * STEPS);
    localparam int unsigned RW = H + 2;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q;
    logic [W-1:0]    x_q;
    logic [H-1:0]    root_q;
    logic [RW-1:0]   rem_q;
    logic [CW-1:0]   cnt_q;

    logic [W-1:0]    x_n;
    logic [H-1:0]    root_n;
    logic [RW-1:0]   rem_n;
    logic [RW-1:0]   rem_sh;
    logic [RW-1:0]   trial;
    logic [H-1:0]    y_fin;
    logic            sat_fin;

    // STEPS iterations chained combinationally; x is consumed MSB pair first.
    always_comb begin
        x_n    = x_q;
        root_n = root_q;
        rem_n  = rem_q;
        rem_sh = '0;
        trial  = '0;
        for (int s = 0; s < int'(STEPS); s++) begin
            rem_sh = {rem_n[RW-3:0], x_n[W-1 -: 2]};
            trial  = {root_n, 2'b01};
            if (rem_sh >= trial) begin
                rem_n  = rem_sh - trial;
                root_n = {root_n[H-2:0], 1'b1};
            end else begin
                rem_n  = rem_sh;
                root_n = {root_n[H-2:0], 1'b0};
            end
            x_n = {x_n[W-3:0], 2'b00};
        end
    end

    // rem > root means x > r^2 + r, i.e. sqrt(x) lies past r + 0.5.
    always_comb begin
        y_fin   = root_n;
        sat_fin = 1'b0;
        if ((ROUND != 0) && (rem_n > {2'b00, root_n})) begin
            if (&root_n) begin
                y_fin   = '1;
                sat_fin = 1'b1;
            end else begin
                y_fin = root_n + H'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            o_done  <= 1'b0;
            o_y     <= '0;
            o_rem   <= '0;
            o_sat   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        x_q     <= i_x;
                        root_q  <= '0;
                        rem_q   <= '0;
                        cnt_q   <= CW'(N);
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    x_q    <= x_n;
                    root_q <= root_n;
                    rem_q  <= rem_n;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= StDone;
                        o_done  <= 1'b1;
                        o_y     <= y_fin;
                        o_rem   <= rem_n[H:0];
                        o_sat   <= sat_fin;
                    end
                end
                StDone: begin
                    o_done  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_ready = (state_q == StIdle);

endmodule

// File: tb/tb_isqrt_seq.sv
// Bench for isqrt_seq: six configurations covering W in {4,8,16,32}, STEPS 1/2, ROUND 0/1.
module tb_isqrt_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start [6];
    logic [31:0] xin   [6];
    logic        ready [6];
    logic        done  [6];
    logic        sat   [6];
    logic [15:0] y     [6];
    logic [16:0] rem   [6];

    int cw [6] = '{16, 16, 16, 4, 8, 32};
    int cr [6] = '{0, 1, 0, 0, 0, 1};

    int checks   = 0;
    int failures = 0;

    logic [7:0]  y0, y1, y2;
    logic [8:0]  r0, r1, r2;
    logic [1:0]  y3;
    logic [2:0]  r3;
    logic [3:0]  y4;
    logic [4:0]  r4;
    logic [15:0] y5;
    logic [16:0] r5;

    isqrt_seq #(.W(16), .STEPS(1), .ROUND(0)) u0 (
        .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_x(xin[0][15:0]),
        .o_ready(ready[0]), .o_done(done[0]), .o_y(y0), .o_rem(r0), .o_sat(sat[0]));
    isqrt_seq #(.W(16), .STEPS(1), .ROUND(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_x(xin[1][15:0]),
        .o_ready(ready[1]), .o_done(done[1]), .o_y(y1), .o_rem(r1), .o_sat(sat[1]));
    isqrt_seq #(.W(16), .STEPS(2), .ROUND(0)) u2 (
        .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_x(xin[2][15:0]),
        .o_ready(ready[2]), .o_done(done[2]), .o_y(y2), .o_rem(r2), .o_sat(sat[2]));
    isqrt_seq #(.W(4), .STEPS(1), .ROUND(0)) u3 (
        .i_clk(clk), .i_rst(rst), .i_start(start[3]), .i_x(xin[3][3:0]),
        .o_ready(ready[3]), .o_done(done[3]), .o_y(y3), .o_rem(r3), .o_sat(sat[3]));
    isqrt_seq #(.W(8), .STEPS(2), .ROUND(0)) u4 (
        .i_clk(clk), .i_rst(rst), .i_start(start[4]), .i_x(xin[4][7:0]),
        .o_ready(ready[4]), .o_done(done[4]), .o_y(y4), .o_rem(r4), .o_sat(sat[4]));
    isqrt_seq #(.W(32), .STEPS(2), .ROUND(1)) u5 (
        .i_clk(clk), .i_rst(rst), .i_start(start[5]), .i_x(xin[5]),
        .o_ready(ready[5]), .o_done(done[5]), .o_y(y5), .o_rem(r5), .o_sat(sat[5]));

    assign y[0] = {8'b0, y0};   assign rem[0] = {8'b0, r0};
    assign y[1] = {8'b0, y1};   assign rem[1] = {8'b0, r1};
    assign y[2] = {8'b0, y2};   assign rem[2] = {8'b0, r2};
    assign y[3] = {14'b0, y3};  assign rem[3] = {14'b0, r3};
    assign y[4] = {12'b0, y4};  assign rem[4] = {12'b0, r4};
    assign y[5] = y5;           assign rem[5] = r5;

    typedef struct {
        int          k;
        logic [31:0] x;
        logic [31:0] ey;
        logic [31:0] er;
        logic        es;
        int          lat;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input int k, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d got=%0d expected=%0d", nm, k, got, exp);
        end
    endtask

    // Reference: largest r with r*r <= x by binary search, then the rounding rule.
    task automatic model(input int w, input int rnd, input longint x,
                         output longint ey, output longint er, output longint es);
        longint lo, hi, mid;
        lo = 0;
        hi = longint'(1) << (w / 2);
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= x) lo = mid;
            else hi = mid;
        end
        ey = lo;
        er = x - lo * lo;
        es = 0;
        if (rnd != 0 && er > lo) begin
            if (lo + 1 == (longint'(1) << (w / 2))) es = 1;
            else ey = lo + 1;
        end
    endtask

    // Counts edges from driving i_start until o_done is seen; ends one edge later, idle again.
    task automatic run(input int k, input logic [31:0] xv, output int lat);
        xin[k]   = xv;
        start[k] = 1'b1;
        lat      = 0;
        do begin
            @(posedge clk); #1;
            start[k] = 1'b0;
            lat++;
        end while (!done[k] && lat < 200);
        chk("done_seen", k, 64'(done[k]), 64'd1);
        @(posedge clk); #1;
        chk("done_one_cycle", k, 64'(done[k]), 64'd0);
    endtask

    initial begin
        int lat;
        int ndone;
        logic [15:0] cy;
        logic [16:0] cr_rem;
        longint ey, er, es;
        logic [31:0] m, xv;

        tbl[0]  = '{0, 32'd0,          32'd0,     32'd0,      1'b0, 9};
        tbl[1]  = '{0, 32'd144,        32'd12,    32'd0,      1'b0, 9};
        tbl[2]  = '{0, 32'd200,        32'd14,    32'd4,      1'b0, 9};
        tbl[3]  = '{0, 32'd65535,      32'd255,   32'd510,    1'b0, 9};
        tbl[4]  = '{1, 32'd65535,      32'd255,   32'd510,    1'b1, 9};
        tbl[5]  = '{1, 32'd210,        32'd14,    32'd14,     1'b0, 9};
        tbl[6]  = '{1, 32'd211,        32'd15,    32'd15,     1'b0, 9};
        tbl[7]  = '{2, 32'd40000,      32'd200,   32'd0,      1'b0, 5};
        tbl[8]  = '{3, 32'd15,         32'd3,     32'd6,      1'b0, 3};
        tbl[9]  = '{3, 32'd0,          32'd0,     32'd0,      1'b0, 3};
        tbl[10] = '{4, 32'd255,        32'd15,    32'd30,     1'b0, 3};
        tbl[11] = '{5, 32'hFFFF_FFFF,  32'd65535, 32'd131070, 1'b1, 9};
        tbl[12] = '{5, 32'd1000000,    32'd1000,  32'd0,      1'b0, 9};
        tbl[13] = '{1, 32'd0,          32'd0,     32'd0,      1'b0, 9};

        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            start[k] = 1'b0;
            xin[k]   = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            chk("rst_ready", k, 64'(ready[k]), 64'd1);
            chk("rst_done", k, 64'(done[k]), 64'd0);
            chk("rst_y", k, 64'(y[k]), 64'd0);
            chk("rst_rem", k, 64'(rem[k]), 64'd0);
            chk("rst_sat", k, 64'(sat[k]), 64'd0);
        end

        for (int i = 0; i < 14; i++) begin
            run(tbl[i].k, tbl[i].x, lat);
            chk("tbl_latency", tbl[i].k, 64'(lat), 64'(tbl[i].lat));
            chk("tbl_y", tbl[i].k, 64'(y[tbl[i].k]), 64'(tbl[i].ey));
            chk("tbl_rem", tbl[i].k, 64'(rem[tbl[i].k]), 64'(tbl[i].er));
            chk("tbl_sat", tbl[i].k, 64'(sat[tbl[i].k]), 64'(tbl[i].es));
        end

        // A second request during CALC must be dropped, and i_x changes ignored.
        xin[0] = 32'd200;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("calc_not_ready", 0, 64'(ready[0]), 64'd0);
        start[0] = 1'b1;
        xin[0] = 32'd144;
        @(posedge clk); #1;
        start[0] = 1'b0;
        ndone = 0;
        cy = '0;
        cr_rem = '0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done[0]) begin
                ndone++;
                cy = y[0];
                cr_rem = rem[0];
            end
        end
        chk("ignore_ndone", 0, 64'(ndone), 64'd1);
        chk("ignore_y", 0, 64'(cy), 64'd14);
        chk("ignore_rem", 0, 64'(cr_rem), 64'd4);
        chk("ignore_ready", 0, 64'(ready[0]), 64'd1);

        xin[0] = 32'd9;
        repeat (5) @(posedge clk);
        #1;
        chk("hold_y", 0, 64'(y[0]), 64'd14);
        chk("hold_rem", 0, 64'(rem[0]), 64'd4);

        // Reset three iterations into a calculation aborts it without o_done.
        xin[0] = 32'd144;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_busy", 0, 64'(ready[0]), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", 0, 64'(ready[0]), 64'd1);
        chk("abort_y", 0, 64'(y[0]), 64'd0);
        chk("abort_rem", 0, 64'(rem[0]), 64'd0);
        chk("abort_sat_other", 1, 64'(sat[1]), 64'd0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done[0]) ndone++;
        end
        chk("abort_no_done", 0, 64'(ndone), 64'd0);

        for (int k = 0; k < 6; k++) begin
            m = (cw[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << cw[k]) - 32'd1);
            for (int i = 0; i < 40; i++) begin
                if (i == 0) xv = m;
                else if (i == 1) xv = 32'd0;
                else xv = $urandom & m;
                run(k, xv, lat);
                model(cw[k], cr[k], longint'({32'b0, xv}), ey, er, es);
                chk("rand_y", k, 64'(y[k]), 64'(ey));
                chk("rand_rem", k, 64'(rem[k]), 64'(er));
                chk("rand_sat", k, 64'(sat[k]), 64'(es));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
